fetch_miss_ctrl: RTL and testbench
==================================

FETCH_MISS_CTRL -- requirements
Module: fetch_miss_ctrl

Interface
REQ-001 The block SHALL have one parameter: LINE_WORDS, default 4, words per cache line; legal values are 2, 4, 8 or 16.
REQ-002 Clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Rst  in  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 pcIn  in  32  current fetch PC from the fetch stage.
REQ-005 hit  in  1  instruction-cache hit for pcIn.
REQ-006 PCSrc  in  1  branch-taken redirect request.
REQ-007 branchTarget  in  32  redirect target, valid when PCSrc=1.
REQ-008 memAck  in  1  memory returns one word this cycle.
REQ-009 memData  in  32  refill word, valid when memAck=1.
REQ-010 stall  out  1  freeze PC and the IF/ID register.
REQ-011 flush  out  1  squash the IF/ID register.
REQ-012 redirect  out  1  PC SHALL load redirectPc this cycle.
REQ-013 redirectPc  out  32  PC load value.
REQ-014 memReq  out  1  refill request, held high for the whole fill.
REQ-015 memAddr  out  32  address of the word being requested.
REQ-016 fillEn  out  1  write fillData into the cache.
REQ-017 fillIdx  out  log2(LINE_WORDS)  word index within the line.
REQ-018 fillData  out  32  equal to memData.
REQ-019 missCount  out  16  number of misses.

Function
REQ-020 The FSM SHALL have four states: IDLE, REQ, FILL, DONE.
REQ-021 In IDLE with hit=0 and PCSrc=0, the FSM SHALL latch lineBase = pcIn with the low log2(LINE_WORDS)+2 bits cleared, and move to REQ on the next edge.
REQ-022 stall SHALL be 1 in IDLE when hit=0 and PCSrc=0, in REQ and in FILL; it SHALL be 0 in DONE and otherwise.
REQ-023 In IDLE with PCSrc=1, the block SHALL drive redirect=1, redirectPc=branchTarget and flush=1, and SHALL NOT start a miss, whatever the value of hit.
REQ-024 REQ SHALL last exactly one cycle with memReq=1 and wordCnt=0, then move to FILL.
REQ-025 In FILL, memReq SHALL be 1 and memAddr SHALL equal lineBase + 4*wordCnt.
REQ-026 In FILL, on each memAck=1 cycle: fillEn=1, fillIdx=wordCnt, fillData=memData, and wordCnt SHALL increment.
REQ-027 memAck=0 cycles in FILL SHALL hold all state, with fillEn=0.
REQ-028 After the ack with wordCnt=LINE_WORDS-1, the FSM SHALL move to DONE.
REQ-029 memAck SHALL be ignored outside FILL.
REQ-030 DONE SHALL last one cycle, then return to IDLE; the fetch stage re-presents pcIn, which now hits.
REQ-031 PCSrc=1 in REQ or FILL SHALL set pendRedir and latch branchTarget into pendTarget; a later PCSrc=1 SHALL overwrite pendTarget.
REQ-032 The fill SHALL always complete; it SHALL NOT be aborted by a redirect.
REQ-033 In DONE with pendRedir=1, the block SHALL drive redirect=1, redirectPc=pendTarget and flush=1, then clear pendRedir.
REQ-034 PCSrc=1 in DONE SHALL take priority over pendTarget.
REQ-035 When redirect=0, redirectPc SHALL be 0.
REQ-036 Refill latency: the miss cycle N gives REQ at N+1, and the first possible fill is at N+2.

Reset
REQ-037 When Rst=1, the block SHALL set state=IDLE, wordCnt=0, lineBase=0, pendRedir=0, pendTarget=0 and missCount=0.
REQ-038 When Rst=1, all outputs SHALL be 0 in the same cycle.
REQ-039 Rst=1 during REQ or FILL SHALL abandon the fill: memReq SHALL drop to 0 after that edge, and the partially written line is the cache's concern.

Configuration
REQ-040 With MISS_COUNTER_EN defined, missCount SHALL increment by 1 on each IDLE-to-REQ transition and saturate at 16'hFFFF.
REQ-041 Without MISS_COUNTER_EN, missCount SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-042 Hit run: hit=1 and PCSrc=0 for 10 cycles -> stall=0, memReq=0 and redirect=0 throughout.
REQ-043 Miss with no wait states: pcIn=0x0000_0048, hit=0, memAck=1 from FILL -> memAddr 0x40, 0x44, 0x48, 0x4C; fillIdx 0..3; stall high 6 cycles (miss cycle, REQ, 4 FILL); DONE follows; missCount=1.
REQ-044 Wait states: memAck pattern 1,0,0,1,1,0,1 -> exactly 4 fillEn pulses; memAddr held during the gaps; DONE follows the 4th ack.
REQ-045 Redirect mid-fill: PCSrc=1 with branchTarget=0x100 at the 2nd fill word, then PCSrc=1 with 0x200 at the 3rd -> fill completes; DONE gives redirect=1, redirectPc=0x200, flush=1.
REQ-046 Simultaneous events in IDLE: hit=0, PCSrc=1, branchTarget=0x80 -> redirect=1, redirectPc=0x80, flush=1; no memReq in the next cycle; missCount unchanged.
REQ-047 Reset mid-fill: Rst=1 after the 2nd ack -> the next cycle shows state IDLE, memReq=0 and missCount=0; a following miss restarts at wordCnt=0.

Source files
------------

// File: rtl/fetch_miss_ctrl.sv
// Instruction-fetch miss controller: stalls fetch on an I-cache miss, refills one line
// word by word, and defers branch redirects until the fill is done. Optional MISS_COUNTER_EN.
module fetch_miss_ctrl #(
    parameter int LINE_WORDS = 4
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [31:0]                   pcIn,
    input  logic                          hit,
    input  logic                          PCSrc,
    input  logic [31:0]                   branchTarget,
    input  logic                          memAck,
    input  logic [31:0]                   memData,
    output logic                          stall,
    output logic                          flush,
    output logic                          redirect,
    output logic [31:0]                   redirectPc,
    output logic                          memReq,
    output logic [31:0]                   memAddr,
    output logic                          fillEn,
    output logic [$clog2(LINE_WORDS)-1:0] fillIdx,
    output logic [31:0]                   fillData,
    output logic [15:0]                   missCount
);

    // state | meaning
    // IDLE  | normal fetch; a miss latches the line base, a redirect passes straight through
    // REQ   | one-cycle refill request, word counter cleared
    // FILL  | collecting LINE_WORDS acked words; redirects are parked in pend_redir/pend_target
    // DONE  | one-cycle tail; releases any parked redirect, then back to IDLE

    localparam int IW = $clog2(LINE_WORDS);
    localparam logic [IW-1:0] LAST_WORD = IW'(LINE_WORDS - 1);
    localparam logic [31:0]   OFF_MASK  = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   word_cnt, word_cnt_nx;
    logic [31:0]     line_base, line_base_nx;
    logic            pend_redir, pend_redir_nx;
    logic [31:0]     pend_target, pend_target_nx;
    logic [31:0]     word_addr;

    assign word_addr = line_base + 32'({word_cnt, 2'b00});

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            word_cnt    <= '0;
            line_base   <= '0;
            pend_redir  <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_nx;
            word_cnt    <= word_cnt_nx;
            line_base   <= line_base_nx;
            pend_redir  <= pend_redir_nx;
            pend_target <= pend_target_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        word_cnt_nx    = word_cnt;
        line_base_nx   = line_base;
        pend_redir_nx  = pend_redir;
        pend_target_nx = pend_target;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect       = 1'b0;
        redirectPc     = '0;
        memReq         = 1'b0;
        memAddr        = '0;
        fillEn         = 1'b0;
        fillIdx        = '0;
        fillData       = memData;

        case (state)
            IDLE: begin
                if (PCSrc) begin
                    redirect   = 1'b1;
                    flush      = 1'b1;
                    redirectPc = branchTarget;
                end else if (!hit) begin
                    stall        = 1'b1;
                    line_base_nx = pcIn & ~OFF_MASK;
                    word_cnt_nx  = '0;
                    state_nx     = REQ;
                end
            end
            REQ: begin
                stall       = 1'b1;
                memReq      = 1'b1;
                memAddr     = word_addr;
                word_cnt_nx = '0;
                state_nx    = FILL;
                if (PCSrc) begin
                    pend_redir_nx  = 1'b1;
                    pend_target_nx = branchTarget;
                end
            end
            FILL: begin
                stall   = 1'b1;
                memReq  = 1'b1;
                memAddr = word_addr;
                if (memAck) begin
                    fillEn      = 1'b1;
                    fillIdx     = word_cnt;
                    // wraps to zero on the last word, ready for the next miss
                    word_cnt_nx = word_cnt + IW'(1);
                    if (word_cnt == LAST_WORD) state_nx = DONE;
                end
                if (PCSrc) begin
                    pend_redir_nx  = 1'b1;
                    pend_target_nx = branchTarget;
                end
            end
            DONE: begin
                if (PCSrc) begin
                    redirect   = 1'b1;
                    flush      = 1'b1;
                    redirectPc = branchTarget;
                end else if (pend_redir) begin
                    redirect   = 1'b1;
                    flush      = 1'b1;
                    redirectPc = pend_target;
                end
                pend_redir_nx = 1'b0;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // reset silences every output in the same cycle
        if (Rst) begin
            stall      = 1'b0;
            flush      = 1'b0;
            redirect   = 1'b0;
            redirectPc = '0;
            memReq     = 1'b0;
            memAddr    = '0;
            fillEn     = 1'b0;
            fillIdx    = '0;
            fillData   = '0;
        end
    end

`ifdef MISS_COUNTER_EN
    logic [15:0] miss_cnt;
    logic        start_miss;

    assign start_miss = (state == IDLE) && !PCSrc && !hit;

    always_ff @(posedge Clk) begin
        if (Rst)
            miss_cnt <= '0;
        else if (start_miss && (miss_cnt != 16'hFFFF))
            miss_cnt <= miss_cnt + 16'd1;
    end

    assign missCount = Rst ? 16'd0 : miss_cnt;
`else
    assign missCount = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_miss_ctrl.sv
// Directed scenarios plus random traffic for fetch_miss_ctrl, checked against a
// cycle-level reference model of the miss/refill/redirect rules.
module tb_fetch_miss_ctrl;

    localparam int LW = 4;
    localparam int IW = $clog2(LW);

    logic          Clk, Rst;
    logic [31:0]   pcIn, branchTarget, memData;
    logic          hit, PCSrc, memAck;
    logic          stall, flush, redirect, memReq, fillEn;
    logic [31:0]   redirectPc, memAddr, fillData;
    logic [IW-1:0] fillIdx;
    logic [15:0]   missCount;

    fetch_miss_ctrl #(.LINE_WORDS(LW)) dut (
        .Clk(Clk), .Rst(Rst), .pcIn(pcIn), .hit(hit), .PCSrc(PCSrc),
        .branchTarget(branchTarget), .memAck(memAck), .memData(memData),
        .stall(stall), .flush(flush), .redirect(redirect), .redirectPc(redirectPc),
        .memReq(memReq), .memAddr(memAddr), .fillEn(fillEn), .fillIdx(fillIdx),
        .fillData(fillData), .missCount(missCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // reference model: where we are in a miss, expressed as counts rather than states
    bit          m_req_next;   // the cycle after a miss
    int          m_words;      // words received so far, -1 when not filling
    bit          m_tail;       // the one cycle after the last word
    bit          m_pend;
    logic [31:0] m_ptgt;
    logic [31:0] m_base;
    int          m_misses;

    int          n_stall, n_fill, n_redir;
    logic [31:0] last_rpc;
    logic [31:0] q_addr[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_obs();
        n_stall = 0;
        n_fill  = 0;
        n_redir = 0;
        last_rpc = '0;
        q_addr.delete();
    endtask

    task automatic step(input logic r, input logic [31:0] pc, input logic h, input logic ps,
                        input logic [31:0] tgt, input logic ack, input logic [31:0] d);
        logic        e_stall, e_flush, e_redir, e_req, e_fen;
        logic [31:0] e_rpc, e_addr, e_fdata, e_idx, e_miss;
        int          line_bytes;
        @(negedge Clk);
        Rst = r; pcIn = pc; hit = h; PCSrc = ps; branchTarget = tgt; memAck = ack; memData = d;
        #1;
        e_stall = 0; e_flush = 0; e_redir = 0; e_req = 0; e_fen = 0;
        e_rpc = 0; e_addr = 0; e_idx = 0;
        e_fdata = r ? 32'd0 : d;
`ifdef MISS_COUNTER_EN
        e_miss = r ? 32'd0 : 32'(m_misses);
`else
        e_miss = 0;
`endif
        line_bytes = LW * 4;
        if (r) begin
            m_req_next = 0; m_words = -1; m_tail = 0; m_pend = 0; m_ptgt = 0; m_base = 0;
            m_misses = 0;
        end else if (m_req_next) begin
            e_stall = 1; e_req = 1; e_addr = m_base;
            if (ps) begin m_pend = 1; m_ptgt = tgt; end
            m_req_next = 0; m_words = 0;
        end else if (m_words >= 0) begin
            e_stall = 1; e_req = 1; e_addr = m_base + 32'(4 * m_words);
            if (ps) begin m_pend = 1; m_ptgt = tgt; end
            if (ack) begin
                e_fen = 1; e_idx = 32'(m_words);
                m_words++;
                if (m_words == LW) begin m_words = -1; m_tail = 1; end
            end
        end else if (m_tail) begin
            if (ps) begin e_redir = 1; e_flush = 1; e_rpc = tgt; end
            else if (m_pend) begin e_redir = 1; e_flush = 1; e_rpc = m_ptgt; end
            m_pend = 0; m_tail = 0;
        end else begin
            if (ps) begin e_redir = 1; e_flush = 1; e_rpc = tgt; end
            else if (!h) begin
                e_stall = 1;
                m_base = (pc / 32'(line_bytes)) * 32'(line_bytes);
                m_req_next = 1;
                if (m_misses < 65535) m_misses++;
            end
        end
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("redirect", 32'(redirect), 32'(e_redir));
        chk("redirectPc", redirectPc, e_rpc);
        chk("memReq", 32'(memReq), 32'(e_req));
        chk("memAddr", memAddr, e_addr);
        chk("fillEn", 32'(fillEn), 32'(e_fen));
        chk("fillIdx", 32'(fillIdx), e_idx);
        chk("fillData", fillData, e_fdata);
        chk("missCount", 32'(missCount), e_miss);
        n_stall += int'(stall);
        n_fill  += int'(fillEn);
        n_redir += int'(redirect);
        if (redirect) last_rpc = redirectPc;
        if (fillEn) q_addr.push_back(memAddr);
    endtask

    logic [31:0] exp_miss;
    logic [31:0] saved_miss;
    bit          ack_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        Rst = 1; pcIn = 0; hit = 1; PCSrc = 0; branchTarget = 0; memAck = 0; memData = 0;
        m_req_next = 0; m_words = -1; m_tail = 0; m_pend = 0; m_ptgt = 0; m_base = 0;
        m_misses = 0;
        clr_obs();

        // reset
        step(1, 32'h1234, 0, 1, 32'h55, 1, 32'hDEAD);
        step(1, 32'h0, 1, 0, 0, 0, 0);

        // hit run
        clr_obs();
        for (int i = 0; i < 10; i++) step(0, 32'(i * 4), 1, 0, 0, 0, 0);
        chk("hitrun_stall_cycles", 32'(n_stall), 32'd0);

        // miss, zero wait states; memAck in REQ must be ignored
        clr_obs();
        step(0, 32'h48, 0, 0, 0, 0, 0);
        step(0, 32'h48, 0, 0, 0, 1, 32'hBAD0);
        for (int i = 0; i < 4; i++) step(0, 32'h48, 0, 0, 0, 1, 32'hA000 + 32'(i));
        chk("miss_stall_cycles", 32'(n_stall), 32'd6);
        chk("miss_fill_pulses", 32'(n_fill), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < q_addr.size()) chk("miss_word_addr", q_addr[i], 32'h40 + 32'(4 * i));
        step(0, 32'h48, 0, 0, 0, 1, 0);
        step(0, 32'h48, 1, 0, 0, 0, 0);
`ifdef MISS_COUNTER_EN
        exp_miss = 32'd1;
`else
        exp_miss = 32'd0;
`endif
        chk("miss_count_after_one", 32'(missCount), exp_miss);

        // wait states
        clr_obs();
        step(0, 32'h1234, 0, 0, 0, 0, 0);
        step(0, 32'h1234, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 32'h1234, 0, 0, 0, ack_pat[i], 32'hB000 + 32'(i));
        chk("wait_fill_pulses", 32'(n_fill), 32'd4);
        step(0, 32'h1234, 0, 0, 0, 1, 0);
        chk("wait_done_stall_cycles", 32'(n_stall), 32'd9);

        // redirect mid-fill: the later target wins
        clr_obs();
        step(0, 32'h2000, 0, 0, 0, 0, 0);
        step(0, 32'h2000, 0, 0, 0, 0, 0);
        step(0, 32'h2000, 0, 0, 0, 1, 1);
        step(0, 32'h2000, 0, 1, 32'h100, 1, 2);
        step(0, 32'h2000, 0, 1, 32'h200, 1, 3);
        step(0, 32'h2000, 0, 0, 0, 1, 4);
        step(0, 32'h2000, 0, 0, 0, 0, 0);
        chk("midfill_redirect_count", 32'(n_redir), 32'd1);
        chk("midfill_redirect_pc", last_rpc, 32'h200);

        // redirect in DONE beats a parked target
        clr_obs();
        step(0, 32'h3000, 0, 0, 0, 0, 0);
        step(0, 32'h3000, 0, 1, 32'h444, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h3000, 0, 0, 0, 1, 0);
        step(0, 32'h3000, 0, 1, 32'h300, 0, 0);
        chk("done_priority_pc", last_rpc, 32'h300);
        step(0, 32'h300, 1, 0, 0, 0, 0);

        // miss and redirect together in IDLE
        clr_obs();
        saved_miss = 32'(missCount);
        step(0, 32'h500, 0, 1, 32'h80, 0, 0);
        chk("idle_both_pc", last_rpc, 32'h80);
        step(0, 32'h80, 1, 0, 0, 0, 0);
        chk("idle_both_no_req", 32'(n_stall), 32'd0);
        chk("idle_both_miss_count", 32'(missCount), saved_miss);

        // reset after the second ack
        clr_obs();
        step(0, 32'h640, 0, 0, 0, 0, 0);
        step(0, 32'h640, 0, 0, 0, 0, 0);
        step(0, 32'h640, 0, 0, 0, 1, 1);
        step(0, 32'h640, 0, 0, 0, 1, 2);
        step(1, 32'h640, 0, 0, 0, 1, 3);
        step(0, 32'h640, 1, 0, 0, 0, 0);
        chk("reset_midfill_miss_count", 32'(missCount), 32'd0);
        clr_obs();
        step(0, 32'h74C, 0, 0, 0, 0, 0);
        step(0, 32'h74C, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h74C, 0, 0, 0, 1, 0);
        if (q_addr.size() > 0) chk("restart_first_addr", q_addr[0], 32'h740);
        chk("restart_fill_pulses", 32'(n_fill), 32'd4);
        step(0, 32'h74C, 1, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 7) == 0),
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 1) == 1,
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
